// File: rtl/udp_cmd_pkg.sv
// Shared constants and types for the UDP command dispatcher: packet type codes,
// header field positions, parser states and error-pulse bit indices.
package udp_cmd_pkg;

    localparam logic [7:0] CMD_TYPE  = 8'h00;
    localparam logic [7:0] DATA_TYPE = 8'hFF;

    localparam int HDR_TYPE_LSB  = 24;
    localparam int HDR_WR_BIT    = 16;
    localparam int HDR_LEN_LSB   = 8;
    localparam int HDR_ID_LSB    = 4;
    localparam int HDR_BURST_LSB = 2;

    localparam int ERR_TRUNC    = 0;
    localparam int ERR_BAD_TYPE = 1;
    localparam int ERR_ADDR_OVF = 2;
    localparam int ERR_DATA_OVF = 3;

    localparam int ADDR_ENTRY_W = 46;
    localparam int DATA_ENTRY_W = 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_ADDR,
        ST_CMD_HDR,
        ST_DATA,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } addr_entry_t;

    function automatic logic [7:0] hdr_type(input logic [31:0] word);
        return word[HDR_TYPE_LSB +: 8];
    endfunction

endpackage

// File: rtl/udp_fwft_fifo.sv
// First-word-fall-through FIFO: head entry is visible on o_dout while o_valid is high.
// Full is judged on the count at the start of the cycle, so a push into a full FIFO is lost.
module udp_fwft_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_valid   = (r_count != '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & o_valid;
    // Head is forced to zero when empty so stale RAM contents never reach the outputs.
    assign o_dout    = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/udp_cmd_dispatch.sv
// Splits the UDP receive word stream into AXI write/read address requests and a write-data stream.
// Optional macro UDP_CMD_ERR_CNT_EN adds saturating per-error counters (err_cnt, err_cnt_clr).
module udp_cmd_dispatch
    import udp_cmd_pkg::*;
#(
    parameter int ADDR_FIFO_DEPTH = 16,
    parameter int DATA_FIFO_DEPTH = 512
) (
    input  logic        gmii_rx_clk,
    input  logic        rstn,
    input  logic        udp_rx_en,
    input  logic [31:0] udp_rx_data,
    input  logic        udp_rx_done,
    output logic [3:0]  MASTER_WR_ADDR_ID,
    output logic [31:0] MASTER_WR_ADDR,
    output logic [7:0]  MASTER_WR_ADDR_LEN,
    output logic [1:0]  MASTER_WR_ADDR_BURST,
    output logic        MASTER_WR_ADDR_VALID,
    input  logic        MASTER_WR_ADDR_READY,
    output logic [3:0]  MASTER_RD_ADDR_ID,
    output logic [31:0] MASTER_RD_ADDR,
    output logic [7:0]  MASTER_RD_ADDR_LEN,
    output logic [1:0]  MASTER_RD_ADDR_BURST,
    output logic        MASTER_RD_ADDR_VALID,
    input  logic        MASTER_RD_ADDR_READY,
    output logic [31:0] wdata,
    output logic        wdata_last,
    output logic        wdata_valid,
    input  logic        wdata_ready,
    output logic [3:0]  err_pulse
`ifdef UDP_CMD_ERR_CNT_EN
    ,
    input  logic        err_cnt_clr,
    output logic [63:0] err_cnt
`endif
);
    state_t      r_state;
    state_t      w_state_next;
    logic        r_hdr_wr;
    logic [7:0]  r_hdr_len;
    logic [3:0]  r_hdr_id;
    logic [1:0]  r_hdr_burst;
    logic [3:0]  r_err_pulse;
    logic [3:0]  w_err_next;
    logic        w_hdr_load;
    logic        w_wr_push;
    logic        w_rd_push;
    logic        w_data_push;
    logic        w_wr_full;
    logic        w_rd_full;
    logic        w_data_full;
    logic [7:0]  w_type;
    addr_entry_t w_new_entry;
    addr_entry_t w_wr_entry;
    addr_entry_t w_rd_entry;
    logic [DATA_ENTRY_W-1:0] w_data_dout;

    assign w_type      = hdr_type(udp_rx_data);
    assign w_new_entry = '{id: r_hdr_id, addr: udp_rx_data, len: r_hdr_len, burst: r_hdr_burst};

    always_ff @(posedge gmii_rx_clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_hdr_wr    <= 1'b0;
            r_hdr_len   <= '0;
            r_hdr_id    <= '0;
            r_hdr_burst <= '0;
            r_err_pulse <= '0;
        end else begin
            r_state     <= w_state_next;
            r_err_pulse <= w_err_next;
            if (w_hdr_load) begin
                r_hdr_wr    <= udp_rx_data[HDR_WR_BIT];
                r_hdr_len   <= udp_rx_data[HDR_LEN_LSB +: 8];
                r_hdr_id    <= udp_rx_data[HDR_ID_LSB +: 4];
                r_hdr_burst <= udp_rx_data[HDR_BURST_LSB +: 2];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_hdr_load   = 1'b0;
        w_wr_push    = 1'b0;
        w_rd_push    = 1'b0;
        w_data_push  = 1'b0;
        w_err_next   = '0;
        if (udp_rx_en) begin
            case (r_state)
                ST_IDLE, ST_CMD_HDR: begin
                    // A header ending its packet has no address word to follow: truncated.
                    if (w_type == CMD_TYPE) begin
                        if (udp_rx_done) begin
                            w_err_next[ERR_TRUNC] = 1'b1;
                            w_state_next          = ST_IDLE;
                        end else begin
                            w_hdr_load   = 1'b1;
                            w_state_next = ST_CMD_ADDR;
                        end
                    end else if (w_type == DATA_TYPE && r_state == ST_IDLE) begin
                        w_state_next = udp_rx_done ? ST_IDLE : ST_DATA;
                    end else begin
                        w_err_next[ERR_BAD_TYPE] = 1'b1;
                        w_state_next             = udp_rx_done ? ST_IDLE : ST_DROP;
                    end
                end
                ST_CMD_ADDR: begin
                    if (r_hdr_wr) begin
                        w_wr_push             = ~w_wr_full;
                        w_err_next[ERR_ADDR_OVF] = w_wr_full;
                    end else begin
                        w_rd_push             = ~w_rd_full;
                        w_err_next[ERR_ADDR_OVF] = w_rd_full;
                    end
                    w_state_next = udp_rx_done ? ST_IDLE : ST_CMD_HDR;
                end
                ST_DATA: begin
                    w_data_push              = ~w_data_full;
                    w_err_next[ERR_DATA_OVF] = w_data_full;
                    w_state_next = udp_rx_done ? ST_IDLE : (w_data_full ? ST_DROP : ST_DATA);
                end
                ST_DROP: begin
                    if (udp_rx_done) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    udp_fwft_fifo #(.WIDTH(ADDR_ENTRY_W), .DEPTH(ADDR_FIFO_DEPTH)) u_wr_fifo (
        .i_clk   (gmii_rx_clk),
        .i_rstn  (rstn),
        .i_push  (w_wr_push),
        .i_din   (w_new_entry),
        .o_full  (w_wr_full),
        .i_pop   (MASTER_WR_ADDR_READY),
        .o_dout  (w_wr_entry),
        .o_valid (MASTER_WR_ADDR_VALID)
    );

    udp_fwft_fifo #(.WIDTH(ADDR_ENTRY_W), .DEPTH(ADDR_FIFO_DEPTH)) u_rd_fifo (
        .i_clk   (gmii_rx_clk),
        .i_rstn  (rstn),
        .i_push  (w_rd_push),
        .i_din   (w_new_entry),
        .o_full  (w_rd_full),
        .i_pop   (MASTER_RD_ADDR_READY),
        .o_dout  (w_rd_entry),
        .o_valid (MASTER_RD_ADDR_VALID)
    );

    udp_fwft_fifo #(.WIDTH(DATA_ENTRY_W), .DEPTH(DATA_FIFO_DEPTH)) u_data_fifo (
        .i_clk   (gmii_rx_clk),
        .i_rstn  (rstn),
        .i_push  (w_data_push),
        .i_din   ({udp_rx_done, udp_rx_data}),
        .o_full  (w_data_full),
        .i_pop   (wdata_ready),
        .o_dout  (w_data_dout),
        .o_valid (wdata_valid)
    );

    assign MASTER_WR_ADDR_ID    = w_wr_entry.id;
    assign MASTER_WR_ADDR       = w_wr_entry.addr;
    assign MASTER_WR_ADDR_LEN   = w_wr_entry.len;
    assign MASTER_WR_ADDR_BURST = w_wr_entry.burst;
    assign MASTER_RD_ADDR_ID    = w_rd_entry.id;
    assign MASTER_RD_ADDR       = w_rd_entry.addr;
    assign MASTER_RD_ADDR_LEN   = w_rd_entry.len;
    assign MASTER_RD_ADDR_BURST = w_rd_entry.burst;
    assign wdata_last           = w_data_dout[32];
    assign wdata                = w_data_dout[31:0];
    assign err_pulse            = r_err_pulse;

`ifdef UDP_CMD_ERR_CNT_EN
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_err_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge gmii_rx_clk) begin
                if (!rstn || err_cnt_clr) begin
                    r_cnt <= '0;
                end else if (r_err_pulse[gi] && r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign err_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_udp_cmd_dispatch.sv
// Directed bench for udp_cmd_dispatch: packet-position model with queues plus literal spot checks.
module tb_udp_cmd_dispatch;
    localparam int AD = 4;
    localparam int DD = 8;
    localparam int K_CMD  = 1;
    localparam int K_DATA = 2;
    localparam int K_SKIP = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        udp_rx_en = 1'b0;
    logic [31:0] udp_rx_data = '0;
    logic        udp_rx_done = 1'b0;
    logic [3:0]  wr_id, rd_id;
    logic [31:0] wr_addr, rd_addr;
    logic [7:0]  wr_len, rd_len;
    logic [1:0]  wr_burst, rd_burst;
    logic        wr_valid, rd_valid;
    logic        wr_ready = 1'b1;
    logic        rd_ready = 1'b1;
    logic [31:0] wdata;
    logic        wdata_last, wdata_valid;
    logic        wdata_ready = 1'b1;
    logic [3:0]  err_pulse;

    int checks = 0;
    int errors = 0;

    // model state
    logic [45:0] m_wr[$];
    logic [45:0] m_rd[$];
    logic [32:0] m_d[$];
    logic [3:0]  exp_err = '0;
    int          m_pos = 0;
    int          m_kind = 0;
    logic [31:0] m_hdr = '0;

    // observations used by literal checks
    logic [32:0] dlog[$];
    int          err_seen[4] = '{0, 0, 0, 0};
    logic [31:0] pkt[$];

    always #4 clk = ~clk;

    udp_cmd_dispatch #(.ADDR_FIFO_DEPTH(AD), .DATA_FIFO_DEPTH(DD)) dut (
        .gmii_rx_clk          (clk),
        .rstn                 (rstn),
        .udp_rx_en            (udp_rx_en),
        .udp_rx_data          (udp_rx_data),
        .udp_rx_done          (udp_rx_done),
        .MASTER_WR_ADDR_ID    (wr_id),
        .MASTER_WR_ADDR       (wr_addr),
        .MASTER_WR_ADDR_LEN   (wr_len),
        .MASTER_WR_ADDR_BURST (wr_burst),
        .MASTER_WR_ADDR_VALID (wr_valid),
        .MASTER_WR_ADDR_READY (wr_ready),
        .MASTER_RD_ADDR_ID    (rd_id),
        .MASTER_RD_ADDR       (rd_addr),
        .MASTER_RD_ADDR_LEN   (rd_len),
        .MASTER_RD_ADDR_BURST (rd_burst),
        .MASTER_RD_ADDR_VALID (rd_valid),
        .MASTER_RD_ADDR_READY (rd_ready),
        .wdata                (wdata),
        .wdata_last           (wdata_last),
        .wdata_valid          (wdata_valid),
        .wdata_ready          (wdata_ready),
        .err_pulse            (err_pulse)
    );

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Model: each word is interpreted by its position within the packet.
    initial begin
        int pre_wr, pre_rd, pre_d;
        logic [31:0] w;
        logic        d;
        logic [45:0] ent;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_wr.delete(); m_rd.delete(); m_d.delete();
                m_pos = 0; m_kind = 0; exp_err = '0;
            end else begin
                exp_err = '0;
                pre_wr = m_wr.size(); pre_rd = m_rd.size(); pre_d = m_d.size();
                if (wr_ready && pre_wr > 0) void'(m_wr.pop_front());
                if (rd_ready && pre_rd > 0) void'(m_rd.pop_front());
                if (wdata_ready && pre_d > 0) void'(m_d.pop_front());
                if (udp_rx_en) begin
                    w = udp_rx_data;
                    d = udp_rx_done;
                    if (m_pos == 0) begin
                        if (w[31:24] == 8'h00) begin
                            if (d) exp_err[0] = 1'b1;
                            else begin m_kind = K_CMD; m_hdr = w; end
                        end else if (w[31:24] == 8'hFF) begin
                            m_kind = K_DATA;
                        end else begin
                            exp_err[1] = 1'b1; m_kind = K_SKIP;
                        end
                    end else if (m_kind == K_CMD) begin
                        if (m_pos % 2 == 1) begin
                            ent = {m_hdr[7:4], w, m_hdr[15:8], m_hdr[3:2]};
                            if (m_hdr[16]) begin
                                if (pre_wr < AD) m_wr.push_back(ent); else exp_err[2] = 1'b1;
                            end else begin
                                if (pre_rd < AD) m_rd.push_back(ent); else exp_err[2] = 1'b1;
                            end
                        end else if (w[31:24] == 8'h00) begin
                            if (d) exp_err[0] = 1'b1; else m_hdr = w;
                        end else begin
                            exp_err[1] = 1'b1; m_kind = K_SKIP;
                        end
                    end else if (m_kind == K_DATA) begin
                        if (pre_d < DD) m_d.push_back({d, w});
                        else begin exp_err[3] = 1'b1; m_kind = K_SKIP; end
                    end
                    m_pos = d ? 0 : m_pos + 1;
                end
            end
        end
    end

    // Compare process: every negedge after the first reset edges.
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            cmp("wr_valid", 64'(wr_valid), 64'(m_wr.size() != 0));
            if (m_wr.size() != 0) cmp("wr_entry", 64'({wr_id, wr_addr, wr_len, wr_burst}), 64'(m_wr[0]));
            cmp("rd_valid", 64'(rd_valid), 64'(m_rd.size() != 0));
            if (m_rd.size() != 0) cmp("rd_entry", 64'({rd_id, rd_addr, rd_len, rd_burst}), 64'(m_rd[0]));
            cmp("wdata_valid", 64'(wdata_valid), 64'(m_d.size() != 0));
            if (m_d.size() != 0) cmp("wdata_word", 64'({wdata_last, wdata}), 64'(m_d[0]));
            cmp("err_pulse", 64'(err_pulse), 64'(exp_err));
            if (wdata_valid && wdata_ready) dlog.push_back({wdata_last, wdata});
            for (int b = 0; b < 4; b++) err_seen[b] += int'(err_pulse[b]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input string nm, input bit with_done);
        for (int i = 0; i < pkt.size(); i++) begin
            udp_rx_en   = 1'b1;
            udp_rx_data = pkt[i];
            udp_rx_done = with_done && (i == pkt.size() - 1);
            @(posedge clk); #1;
        end
        udp_rx_en = 1'b0; udp_rx_done = 1'b0; udp_rx_data = '0;
        $display("[tb] t=%0t packet %s: %0d words%s", $time, nm, pkt.size(), with_done ? "" : " (no done)");
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst_wr_valid", 64'(wr_valid), 64'd0);
        cmp("rst_rd_valid", 64'(rd_valid), 64'd0);
        cmp("rst_wdata_valid", 64'(wdata_valid), 64'd0);
        cmp("rst_err", 64'(err_pulse), 64'd0);
        cmp("rst_fields", 64'({wr_addr, rd_addr}), 64'd0);
        cmp("rst_wdata", 64'(wdata), 64'd0);
        @(posedge clk); #1; rstn = 1'b1;
        idle(2);

        // 1: single write command
        pkt = '{32'h00010F34, 32'h10000000};
        send("t1_wr_cmd", 1);
        @(negedge clk);
        cmp("t1_wr_valid", 64'(wr_valid), 64'd1);
        cmp("t1_wr_id", 64'(wr_id), 64'd3);
        cmp("t1_wr_addr", 64'(wr_addr), 64'h10000000);
        cmp("t1_wr_len", 64'(wr_len), 64'h0F);
        cmp("t1_wr_burst", 64'(wr_burst), 64'd1);
        cmp("t1_rd_valid", 64'(rd_valid), 64'd0);
        idle(3);

        // 2: read + write command in one packet
        wr_ready = 1'b0; rd_ready = 1'b0;
        pkt = '{32'h00000704, 32'h20000040, 32'h00010004, 32'h30000000};
        send("t2_rd_wr", 1);
        @(negedge clk);
        cmp("t2_rd_entry", 64'({rd_id, rd_addr, rd_len, rd_burst}), 64'({4'd0, 32'h20000040, 8'd7, 2'd1}));
        cmp("t2_wr_entry", 64'({wr_id, wr_addr, wr_len, wr_burst}), 64'({4'd0, 32'h30000000, 8'd0, 2'd1}));
        @(posedge clk); #1; wr_ready = 1'b1; rd_ready = 1'b1;
        idle(3);

        // 3: data packet
        dlog.delete();
        pkt = '{32'hFF000000, 32'hD0D0D0D0, 32'hD1D1D1D1, 32'hD2D2D2D2, 32'hD3D3D3D3};
        send("t3_data", 1);
        idle(4);
        cmp("t3_beats", 64'(dlog.size()), 64'd4);
        if (dlog.size() == 4) begin
            cmp("t3_beat0", 64'(dlog[0]), 64'({1'b0, 32'hD0D0D0D0}));
            cmp("t3_beat2", 64'(dlog[2]), 64'({1'b0, 32'hD2D2D2D2}));
            cmp("t3_beat3", 64'(dlog[3]), 64'({1'b1, 32'hD3D3D3D3}));
        end

        // 4: truncated command, then a normal one
        e = err_seen[0];
        pkt = '{32'h00010F34};
        send("t4_trunc", 1);
        idle(2);
        cmp("t4_trunc_pulses", 64'(err_seen[0] - e), 64'd1);
        cmp("t4_no_push", 64'(wr_valid), 64'd0);
        pkt = '{32'h00010F54, 32'h40000000};
        send("t4_after", 1);
        @(negedge clk);
        cmp("t4_wr_id", 64'(wr_id), 64'd5);
        idle(3);

        // 5: address FIFO overflow with READY low
        wr_ready = 1'b0;
        e = err_seen[2];
        pkt.delete();
        for (int k = 1; k <= 5; k++) begin
            pkt.push_back(32'h00010000 | (32'(k) << 4));
            pkt.push_back(32'h1000 * k);
        end
        send("t5_five_wr", 1);
        idle(2);
        cmp("t5_ovf_pulses", 64'(err_seen[2] - e), 64'd1);
        wr_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            cmp("t5_drain_id", 64'(wr_id), 64'(k));
            @(posedge clk); #1;
        end
        @(negedge clk);
        cmp("t5_drained", 64'(wr_valid), 64'd0);
        idle(2);

        // data FIFO overflow: 10 words into depth 8, rest of packet dropped
        wdata_ready = 1'b0;
        e = err_seen[3];
        pkt = '{32'hFF000000};
        for (int k = 0; k < 10; k++) pkt.push_back(32'hA0000000 + k);
        send("dovf", 1);
        idle(2);
        cmp("dovf_pulses", 64'(err_seen[3] - e), 64'd1);
        dlog.delete();
        wdata_ready = 1'b1;
        idle(12);
        cmp("dovf_beats", 64'(dlog.size()), 64'd8);
        if (dlog.size() == 8) cmp("dovf_last_beat", 64'(dlog[7]), 64'({1'b0, 32'hA0000007}));

        // 6: bad type packet, then reset mid-DATA
        e = err_seen[1];
        pkt = '{32'h55000000, 32'h11111111, 32'h22222222};
        send("t6_bad", 1);
        idle(2);
        cmp("t6_bad_pulses", 64'(err_seen[1] - e), 64'd1);
        cmp("t6_no_data", 64'(wdata_valid), 64'd0);

        wdata_ready = 1'b0; wr_ready = 1'b0;
        pkt = '{32'hFF000000, 32'h00000001, 32'h00000002, 32'h00000003};
        send("t6_data_partial", 0);
        @(negedge clk);
        cmp("t6_pre_rst_valid", 64'(wdata_valid), 64'd1);
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        cmp("t6_rst_wdata_valid", 64'(wdata_valid), 64'd0);
        cmp("t6_rst_wr_valid", 64'(wr_valid), 64'd0);
        cmp("t6_rst_rd_valid", 64'(rd_valid), 64'd0);
        @(posedge clk); #1; rstn = 1'b1; wdata_ready = 1'b1; wr_ready = 1'b1;
        pkt = '{32'h00000008, 32'h50000000};
        send("t6_after_rst", 1);
        @(negedge clk);
        cmp("t6_rd_addr", 64'(rd_addr), 64'h50000000);
        cmp("t6_rd_burst", 64'(rd_burst), 64'd2);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_cmd_dispatch.md
Name: udp_cmd_dispatch

Overview:
Parses the 32-bit UDP receive word stream into AXI address requests and a write-data stream. Generalises the single-command UDP decoder: multiple commands per packet, parametrised FIFO depths, live AXI WR/RD address channels, error detection. Sits between the UDP receive path (gmii_rx_clk domain) and the AXI master write/read engines.

Parameters:
ADDR_FIFO_DEPTH, 16, entries in each of the write-address and read-address FIFOs (power of 2, >=2)
DATA_FIFO_DEPTH, 512, entries in the write-data FIFO (power of 2, >=4)

Ports:
gmii_rx_clk  in  1  clock, 125 MHz
rstn  in  1  reset; synchronous, active-low
udp_rx_en  in  1  udp_rx_data valid this cycle; no backpressure
udp_rx_data  in  32  received word
udp_rx_done  in  1  asserted with udp_rx_en on the last word of a packet
MASTER_WR_ADDR_ID  out  4  write command ID
MASTER_WR_ADDR  out  32  write address
MASTER_WR_ADDR_LEN  out  8  burst length - 1
MASTER_WR_ADDR_BURST  out  2  burst type
MASTER_WR_ADDR_VALID  out  1  write-address FIFO not empty
MASTER_WR_ADDR_READY  in  1  pop write-address entry
MASTER_RD_ADDR_ID / _ADDR / _LEN / _BURST  out  4/32/8/2  read command fields, same layout
MASTER_RD_ADDR_VALID  out  1  read-address FIFO not empty
MASTER_RD_ADDR_READY  in  1  pop read-address entry
wdata  out  32  write-data stream word
wdata_last  out  1  word was last of its UDP packet
wdata_valid  out  1  data FIFO not empty
wdata_ready  in  1  pop data word
err_pulse  out  4  one-cycle pulses: [0] truncated cmd, [1] bad type, [2] addr FIFO overflow, [3] data FIFO overflow

Behaviour:
- Command header word: [31:24]=8'h00; [16]=1 write / 0 read; [15:8] LEN; [7:4] ID; [3:2] BURST; other bits ignored. Next word = ADDR. A command packet carries 1..N header/address pairs.
- Data packet: first word [31:24]=8'hFF (not forwarded); every following word is pushed as {udp_rx_done, udp_rx_data}.
- States: IDLE (expect packet start), CMD_ADDR (expect address), CMD_HDR (expect next header in same packet), DATA, DROP.
- IDLE, on rx_en: type 00 -> latch header, CMD_ADDR; type FF -> DATA; any other type -> err[1], DROP. If done is set on this word: type 00 -> err[0], IDLE; type FF -> IDLE, nothing output; other -> err[1], IDLE.
- CMD_ADDR, on rx_en: push {ID,ADDR,LEN,BURST} to the write or read FIFO per bit 16. Target FIFO full -> no push, err[2]. Next state: done ? IDLE : CMD_HDR.
- CMD_HDR, on rx_en: type 00 -> latch, CMD_ADDR (done set -> err[0], IDLE); other type -> err[1], done ? IDLE : DROP.
- DATA, on rx_en: push word. FIFO full -> word lost, err[3], done ? IDLE : DROP (rest of packet discarded). done -> IDLE.
- DROP: discard words; rx_en&done -> IDLE.
- All FIFOs first-word-fall-through. Word accepted at cycle N -> VALID high at N+1 if FIFO was empty. Pop on VALID&READY.
- Full is evaluated on the pre-cycle count: push while full is rejected even if a pop occurs in the same cycle. Simultaneous push and pop on a non-full FIFO keeps the count. Pointers wrap modulo depth.
- Reset values: all VALID=0, err_pulse=0, data/field outputs 0, FIFOs empty, state IDLE. Reset mid-packet discards all state. The first word after reset is treated as a packet start.

Optional Feature:
UDP_CMD_ERR_CNT_EN: adds four 16-bit saturating counters, one per err_pulse bit, output as err_cnt (64 bits, bit [0]'s counter in [15:0]), and clear input err_cnt_clr (1 bit, synchronous). Counters hold at 16'hFFFF. Clear has priority over an increment in the same cycle. Without the macro, neither port nor the counters exist; err_pulse behaviour is identical.

Decomposition:
- Package udp_cmd_pkg: type codes CMD_TYPE=8'h00, DATA_TYPE=8'hFF; header bit positions; state encoding; err_pulse index constants.
- One sub-module, udp_fwft_fifo #(WIDTH, DEPTH), instantiated three times: write-address (46 bits), read-address (46 bits), data (33 bits).

Test Plan:
1. Packet 0x00010F34, 0x10000000 (done) -> next cycle WR_ADDR_VALID=1, ID=3, ADDR=0x10000000, LEN=0x0F, BURST=01; RD_ADDR_VALID stays 0.
2. One packet 0x00000704, 0x20000040, 0x00010004, 0x30000000 (done) -> RD entry (LEN=7, ID=0, BURST=01, ADDR=0x20000040) and WR entry (LEN=0, ADDR=0x30000000).
3. Packet 0xFF000000, D0..D3 (done on D3), wdata_ready=1 -> four beats D0..D3, wdata_last only on D3, header not forwarded.
4. Single word 0x00010F34 with done -> err_pulse[0] for one cycle, no push; following valid command packet dispatches normally.
5. ADDR_FIFO_DEPTH=4, MASTER_WR_ADDR_READY=0, five write commands -> 4 entries, err_pulse[2] once; READY=1 drains 4 in order.
6. Packet 0x55000000 + 2 words -> err_pulse[1], words ignored. rstn=0 mid-DATA -> all VALIDs 0 next cycle, FIFOs empty.
